systolic_inject_ctrl: RTL
=========================

# systolic_inject_ctrl

Tile-level sequencer for the 32x32 systolic array's staggered-injection front end. It broadcasts `fifo_load` and `fifo_read_en` to every row/column injection FIFO and runs the array through the inject and drain phases. It then streams the N result rows out over a valid/ready handshake. It sits between the tile scheduler (start/done) and the array, and also checks the FIFOs' completion flags.

## Interface
Parameters:
- `N`, 32: array dimension; number of injection FIFOs per side and result rows.
- `INJ_DEPTH`, 64: injection FIFO depth; number of `fifo_read_en` cycles per tile.
- `DRAIN_CYCLES`, 32: cycles after the last injection during which the array keeps computing.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a tile; accepted only when `ready`=1.
- `acc_clear_req`  in  1  sampled with an accepted `start`; 1 = clear array accumulators for this tile.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last result row is accepted.
- `fifo_load`  out  1  broadcast parallel-load strobe to all injection FIFOs.
- `fifo_read_en`  out  1  broadcast read enable to all injection FIFOs.
- `fifo_complete`  in  2N  completion flags from all row and column FIFOs.
- `array_en`  out  1  array compute enable.
- `acc_clear`  out  1  one-cycle accumulator clear.
- `res_valid`  out  1  result row valid.
- `res_ready`  in  1  downstream accepts the row.
- `res_row`  out  $clog2(N)  index of the presented row.
- `err`  out  1  sticky error: completion mismatch at end of injection.

## Operation
The controller is an FSM with the states IDLE, LOAD, INJECT, DRAIN and OUTPUT.
- **IDLE:** `ready`=1. On `start`, latch `acc_clear_req`, clear `err`, and go to LOAD.
- **LOAD:** one cycle with `fifo_load`=1 and `acc_clear`=latched request. Go to INJECT with `cnt`=0.
- **INJECT:** `fifo_read_en`=1 and `array_en`=1 for exactly `INJ_DEPTH` cycles.
  - `cnt` increments each cycle.
  - At `cnt`==`INJ_DEPTH`-1, go to DRAIN with `cnt`=0.
- **DRAIN:** `array_en`=1 and `fifo_read_en`=0 for `DRAIN_CYCLES` cycles.
  - In the first DRAIN cycle, `fifo_complete` must be all ones; otherwise set `err`.
  - `err` stays set until the next accepted `start` or `rst`.
  - At the last count, go to OUTPUT with `res_row`=0.
- **OUTPUT:** `res_valid`=1 and `array_en`=0.
  - On `res_valid`&&`res_ready`, increment `res_row`.
  - On acceptance of row N-1, go to IDLE and pulse `done`.
- Flags are not checked during INJECT. A flag rising early is not an error; only the first-DRAIN-cycle value matters.
- `cnt` is wide enough for max(`INJ_DEPTH`,`DRAIN_CYCLES`). It does not wrap inside a phase.
- `err` does not abort the tile; the tile always completes.

## Timing
- **Reset values:** state=IDLE, `ready`=1, and every other output = 0 (`res_row`=0).
- **Reset mid-operation:** `rst` in any state returns to IDLE on the next edge. All strobes drop in that edge and no `done` is issued.
- **Tile start:** `start` is accepted in cycle 0 (IDLE).
  - Cycle 1: LOAD.
  - Cycles 2..`INJ_DEPTH`+1: INJECT.
  - Next `DRAIN_CYCLES` cycles: DRAIN.
  - Then OUTPUT.
- **Defaults:** LOAD at cycle 1, INJECT at cycles 2..65, DRAIN at 66..97, first `res_valid` at cycle 98.
- **Result handshake:**
  - Rows advance only on a handshake.
  - `res_valid` stays high and `res_row` stays stable while `res_ready`=0.
  - With `res_ready` held high, one row per cycle is transferred.
- **done:** asserts in the cycle after the handshake of row N-1, coincident with IDLE and `ready`=1. With `res_ready` held high, that is cycle 130.
- **Back-to-back tiles:** `start` may be asserted in the `done` cycle and is accepted. Minimum tile period is `INJ_DEPTH`+`DRAIN_CYCLES`+N+2 cycles.
- **Ignored starts:** `start` while `busy` is ignored and not queued.
- **Strobe exclusivity:** `fifo_load` and `fifo_read_en` are never high in the same cycle.

## Test plan
- **Basic tile:** reset, then `start`=1 with `acc_clear_req`=1 and `res_ready`=1 constantly, all `fifo_complete` high by cycle 66.
  - `fifo_load` and `acc_clear` high in cycle 1 only.
  - `fifo_read_en` high in cycles 2..65 (64 cycles).
  - `res_valid` from 98, rows 0..31, `done` in cycle 130, `err`=0.
- **Backpressure:** drop `res_ready` for 5 cycles at row 7.
  - `res_row` holds 7 with `res_valid`=1.
  - `done` is delayed by exactly 5 cycles.
- **Completion error:** bit 40 of `fifo_complete` is low in cycle 66.
  - `err`=1 from cycle 67 through `done`.
  - `err` clears when the next `start` is accepted.
- **Reset mid-INJECT:** `rst` at cycle 30.
  - Next cycle: `fifo_read_en`=0, `ready`=1, no `done`.
  - A new `start` restarts the tile from LOAD.
- **Start while busy:** `start` pulses at cycles 10 and 100 have no effect. A `start` in the `done` cycle begins LOAD next cycle, and `acc_clear`=0 when `acc_clear_req`=0.
- **Parameter sweep:** run with `N`=4, `INJ_DEPTH`=8, `DRAIN_CYCLES`=4.
  - Exactly 8 `fifo_read_en` cycles and 4 rows.
  - `done` at cycle 1+8+4+4+1 = 18.

Source files
------------

// File: rtl/systolic_inject_ctrl.sv
// Tile sequencer for the systolic array injection front end: load, inject, drain,
// then stream result rows over a valid/ready handshake.
module systolic_inject_ctrl #(
    parameter int unsigned N            = 32,
    parameter int unsigned INJ_DEPTH    = 64,
    parameter int unsigned DRAIN_CYCLES = 32,
    localparam int unsigned RowW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            acc_clear_req,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            fifo_load,
    output logic            fifo_read_en,
    input  logic [2*N-1:0]  fifo_complete,
    output logic            array_en,
    output logic            acc_clear,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RowW-1:0] res_row,
    output logic            err
);

    localparam int unsigned CntMax = (INJ_DEPTH > DRAIN_CYCLES) ? INJ_DEPTH : DRAIN_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] InjLast   = CntW'(INJ_DEPTH - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYCLES - 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(N - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StInject, StDrain, StOutput} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RowW-1:0]   row_q, row_d;
    logic              acc_clr_q, acc_clr_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_q     <= '0;
            acc_clr_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            acc_clr_q <= acc_clr_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        acc_clr_d = acc_clr_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_clr_d = acc_clear_req;
                    err_d     = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StInject;
            end
            StInject: begin
                if (cnt_q == InjLast) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                // Completion flags only matter on the first drain cycle.
                if (cnt_q == '0 && !(&fifo_complete)) begin
                    err_d = 1'b1;
                end
                if (cnt_q == DrainLast) begin
                    row_d   = '0;
                    state_d = StOutput;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOutput: begin
                if (res_ready) begin
                    if (row_q == RowLast) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready        = (state_q == StIdle);
        busy         = (state_q != StIdle);
        fifo_load    = (state_q == StLoad);
        acc_clear    = (state_q == StLoad) && acc_clr_q;
        fifo_read_en = (state_q == StInject);
        array_en     = (state_q == StInject) || (state_q == StDrain);
        res_valid    = (state_q == StOutput);
        res_row      = row_q;
        err          = err_q;
        done         = done_q;
    end

endmodule
